// File: rtl/dmem_arbiter.sv
// Core / loader arbiter for the shared single-port data memory.
// Define DMEM_ARB_RR_EN for round-robin contention in IDLE (else core wins).
module dmem_arbiter #(
  parameter int DEPTH_LOG2 = 8,
  parameter int DATA_W     = 32,
  parameter int MAX_LOCK   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  c_req,
  input  logic                  c_we,
  input  logic [DEPTH_LOG2-1:0] c_addr,
  input  logic [DATA_W-1:0]     c_wdata,
  output logic                  c_gnt,
  output logic                  c_stall,
  output logic                  c_rvalid,
  output logic [DATA_W-1:0]     c_rdata,
  input  logic                  l_req,
  input  logic                  l_we,
  input  logic [DEPTH_LOG2-1:0] l_addr,
  input  logic [DATA_W-1:0]     l_wdata,
  input  logic                  l_lock,
  output logic                  l_gnt,
  output logic                  l_rvalid,
  output logic [DATA_W-1:0]     l_rdata,
  output logic                  m_en,
  output logic                  m_we,
  output logic [DEPTH_LOG2-1:0] m_addr,
  output logic [DATA_W-1:0]     m_wdata,
  input  logic [DATA_W-1:0]     m_rdata
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOCK,
    S_BREAK
  } state_t;

  localparam logic [7:0] MAX_L = 8'(MAX_LOCK);

  state_t     state;
  logic [7:0] cnt;
  logic [7:0] cnt_inc;
  logic       c_win;
  logic       l_win;
  logic       pick_l;

`ifdef DMEM_ARB_RR_EN
  logic rr_l;
  assign pick_l = rr_l;
`else
  assign pick_l = 1'b0;
`endif

  always_comb begin
    c_win = 1'b0;
    l_win = 1'b0;
    case (state)
      S_IDLE: begin
        if (c_req && l_req) begin
          l_win = pick_l;
          c_win = ~pick_l;
        end else begin
          c_win = c_req;
          l_win = l_req;
        end
      end
      S_LOCK:  l_win = l_req;
      S_BREAK: c_win = c_req;
      default: ;
    endcase
  end

  // Grants are forced low for the whole time reset is held.
  assign c_gnt   = c_win & rst;
  assign l_gnt   = l_win & rst;
  assign c_stall = c_req & ~c_gnt;

  assign m_en    = c_gnt | l_gnt;
  assign m_we    = l_gnt ? l_we    : c_we;
  assign m_addr  = l_gnt ? l_addr  : c_addr;
  assign m_wdata = l_gnt ? l_wdata : c_wdata;

  assign c_rdata = m_rdata;
  assign l_rdata = m_rdata;

  assign cnt_inc = cnt + {7'd0, c_req & l_gnt};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      cnt      <= 8'd0;
      c_rvalid <= 1'b0;
      l_rvalid <= 1'b0;
`ifdef DMEM_ARB_RR_EN
      rr_l     <= 1'b0;
`endif
    end else begin
      c_rvalid <= c_gnt & ~c_we;
      l_rvalid <= l_gnt & ~l_we;
      case (state)
        S_IDLE: begin
          if (l_gnt && l_lock) begin
            state <= S_LOCK;
            cnt   <= 8'd0;
          end
        end
        S_LOCK: begin
          cnt <= cnt_inc;
          if (!l_lock)
            state <= S_IDLE;
          else if (c_req && cnt_inc >= MAX_L)
            state <= S_BREAK;
        end
        S_BREAK: begin
          cnt   <= 8'd0;
          state <= l_lock ? S_LOCK : S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
`ifdef DMEM_ARB_RR_EN
      if (state == S_IDLE && c_req && l_req)
        rr_l <= ~rr_l;
`endif
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus
// randomized traffic against a cycle-level reference model.
module tb_dmem_arbiter;

  localparam int ML = 4;
`ifdef DMEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        c_req = 1'b0, c_we = 1'b0;
  logic [7:0]  c_addr = '0;
  logic [31:0] c_wdata = '0;
  logic        c_gnt, c_stall, c_rvalid;
  logic [31:0] c_rdata;
  logic        l_req = 1'b0, l_we = 1'b0, l_lock = 1'b0;
  logic [7:0]  l_addr = '0;
  logic [31:0] l_wdata = '0;
  logic        l_gnt, l_rvalid;
  logic [31:0] l_rdata;
  logic        m_en, m_we;
  logic [7:0]  m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata;

  logic [31:0] mem [0:255];
  logic [31:0] sh  [0:255];

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  always @(posedge clk)
    if (m_en) begin
      if (m_we) mem[m_addr] <= m_wdata;
      else      m_rdata <= mem[m_addr];
    end

  dmem_arbiter #(
    .DEPTH_LOG2(8),
    .DATA_W(32),
    .MAX_LOCK(ML)
  ) dut (
    .clk(clk), .rst(rst),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr),
    .c_wdata(c_wdata), .c_gnt(c_gnt), .c_stall(c_stall),
    .c_rvalid(c_rvalid), .c_rdata(c_rdata),
    .l_req(l_req), .l_we(l_we), .l_addr(l_addr),
    .l_wdata(l_wdata), .l_lock(l_lock), .l_gnt(l_gnt),
    .l_rvalid(l_rvalid), .l_rdata(l_rdata),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_rdata(m_rdata)
  );

  function automatic logic [31:0] val(int i);
    return (i == 3) ? 32'h0000_00A5 : (32'hC0DE_0000 | i);
  endfunction

  task automatic idle_in();
    c_req = 0; c_we = 0; l_req = 0; l_we = 0; l_lock = 0;
  endtask

  task automatic preload();
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      c_req = 0; l_lock = 0;
      l_req = 1; l_we = 1; l_addr = 8'(i); l_wdata = val(i);
      sh[i] = val(i);
    end
    @(negedge clk);
    idle_in();
  endtask

  task automatic test_reset();
    rst = 0;
    c_req = 1; l_req = 1; c_addr = 8'd1; l_addr = 8'd2;
    @(negedge clk); #1;
    nvec++;
    if (c_gnt !== 1'b0 || l_gnt !== 1'b0 || m_en !== 1'b0) begin
      nerr++;
      $display("FAIL reset_gnt got c%b l%b en%b want 000",
               c_gnt, l_gnt, m_en);
    end
    @(posedge clk); #1;
    nvec++;
    if (c_rvalid !== 1'b0 || l_rvalid !== 1'b0) begin
      nerr++;
      $display("FAIL reset_rvalid got c%b l%b want 00",
               c_rvalid, l_rvalid);
    end
    @(negedge clk);
    idle_in();
    rst = 1;
  endtask

  task automatic test_core_read();
    @(negedge clk);
    idle_in();
    c_req = 1; c_we = 0; c_addr = 8'd3;
    #1;
    nvec++;
    if (c_gnt !== 1'b1 || c_stall !== 1'b0 || m_addr !== 8'd3) begin
      nerr++;
      $display("FAIL core_read_gnt got g%b s%b a%0d want g1 s0 a3",
               c_gnt, c_stall, m_addr);
    end
    @(posedge clk); #1;
    nvec++;
    if (c_rvalid !== 1'b1 || c_rdata !== 32'hA5 || l_rvalid !== 1'b0) begin
      nerr++;
      $display("FAIL core_read_data got v%b d%h lv%b want v1 d000000a5 lv0",
               c_rvalid, c_rdata, l_rvalid);
    end
    @(negedge clk);
    idle_in();
    @(posedge clk); #1;
    nvec++;
    if (c_rvalid !== 1'b0) begin
      nerr++;
      $display("FAIL core_read_pulse got %b want 0", c_rvalid);
    end
  endtask

  task automatic test_contention();
    bit ec, el;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      c_req = 1; c_we = 0; c_addr = 8'd1;
      l_req = 1; l_we = 0; l_addr = 8'd2; l_lock = 0;
      #1;
      ec = RR ? (k % 2 == 0) : 1'b1;
      el = !ec;
      nvec++;
      if (c_gnt !== ec || l_gnt !== el || c_stall !== el) begin
        nerr++;
        $display("FAIL contend_gnt k%0d got c%b l%b s%b want c%b l%b s%b",
                 k, c_gnt, l_gnt, c_stall, ec, el, el);
      end
      @(posedge clk); #1;
      nvec++;
      if (c_rvalid !== ec || l_rvalid !== el) begin
        nerr++;
        $display("FAIL contend_rv k%0d got c%b l%b want c%b l%b",
                 k, c_rvalid, l_rvalid, ec, el);
      end
      nvec++;
      if ((ec ? c_rdata : l_rdata) !== (ec ? val(1) : val(2))) begin
        nerr++;
        $display("FAIL contend_data k%0d got %h want %h", k,
                 ec ? c_rdata : l_rdata, ec ? val(1) : val(2));
      end
    end
    @(negedge clk);
    idle_in();
  endtask

  task automatic test_reset_mid_read();
    @(negedge clk);
    idle_in();
    c_req = 1; c_we = 0; c_addr = 8'd3;
    #1;
    nvec++;
    if (c_gnt !== 1'b1) begin
      nerr++;
      $display("FAIL midrst_gnt got %b want 1", c_gnt);
    end
    @(posedge clk); #2;
    rst = 0;
    #1;
    nvec++;
    if (c_rvalid !== 1'b0) begin
      nerr++;
      $display("FAIL midrst_clear got %b want 0", c_rvalid);
    end
    @(negedge clk); #1;
    nvec++;
    if (c_gnt !== 1'b0 || m_en !== 1'b0) begin
      nerr++;
      $display("FAIL midrst_gnt_low got g%b en%b want 00", c_gnt, m_en);
    end
    @(negedge clk);
    idle_in();
    rst = 1;
    @(posedge clk); #1;
    nvec++;
    if (c_rvalid !== 1'b0 || l_rvalid !== 1'b0) begin
      nerr++;
      $display("FAIL midrst_after got c%b l%b want 00", c_rvalid, l_rvalid);
    end
    test_core_read();
  endtask

  task automatic test_write_then_read();
    @(negedge clk);
    idle_in();
    c_req = 1; c_we = 1; c_addr = 8'd10; c_wdata = 32'h0000_1234;
    #1;
    nvec++;
    if (c_gnt !== 1'b1 || m_we !== 1'b1 || m_wdata !== 32'h1234) begin
      nerr++;
      $display("FAIL wr_gnt got g%b we%b d%h want g1 we1 d00001234",
               c_gnt, m_we, m_wdata);
    end
    @(negedge clk);
    idle_in();
    l_req = 1; l_we = 0; l_addr = 8'd10;
    #1;
    nvec++;
    if (l_gnt !== 1'b1) begin
      nerr++;
      $display("FAIL rd_gnt got %b want 1", l_gnt);
    end
    @(posedge clk); #1;
    nvec++;
    if (l_rvalid !== 1'b1 || l_rdata !== 32'h1234 || c_rvalid !== 1'b0) begin
      nerr++;
      $display("FAIL wr_rd got lv%b d%h cv%b want lv1 d00001234 cv0",
               l_rvalid, l_rdata, c_rvalid);
    end
    @(negedge clk);
    idle_in();
  endtask

  task automatic test_lock_break();
    logic [8:0] creq_p = 9'b000111110;
    logic [8:0] egl_p  = 9'b111011111;
    logic [8:0] egc_p  = 9'b000100000;
    int a = 0;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      c_req = creq_p[k]; c_we = 0; c_addr = 8'd5;
      l_req = 1; l_we = 1; l_addr = 8'(a);
      l_wdata = 32'hBEEF_0000 | a;
      l_lock = (a != 7);
      #1;
      nvec++;
      if (l_gnt !== egl_p[k] || c_gnt !== egc_p[k] ||
          c_stall !== (creq_p[k] & ~egc_p[k])) begin
        nerr++;
        $display("FAIL lock k%0d got l%b c%b s%b want l%b c%b s%b",
                 k, l_gnt, c_gnt, c_stall, egl_p[k], egc_p[k],
                 creq_p[k] & ~egc_p[k]);
      end
      if (l_gnt) a++;
      @(posedge clk); #1;
      nvec++;
      if (c_rvalid !== egc_p[k]) begin
        nerr++;
        $display("FAIL lock_rv k%0d got %b want %b", k, c_rvalid, egc_p[k]);
      end
      if (egc_p[k]) begin
        nvec++;
        if (c_rdata !== val(5)) begin
          nerr++;
          $display("FAIL lock_brk_data got %h want %h", c_rdata, val(5));
        end
      end
    end
    @(negedge clk);
    idle_in();
    nvec++;
    if (a != 8 || mem[7] !== 32'hBEEF_0007 || mem[4] !== 32'hBEEF_0004) begin
      nerr++;
      $display("FAIL lock_writes got n%0d m7 %h m4 %h want n8 beef0007 beef0004",
               a, mem[7], mem[4]);
    end
  endtask

  task automatic test_random();
    int mode = 0;
    int run = 0;
    bit fav_l = 0;
    bit cg = 1, lg = 1;
    bit ec, el, ecr, elr;
    logic [31:0] exp_rd;
    @(negedge clk);
    idle_in();
    rst = 0;
    @(negedge clk);
    rst = 1;
    preload();
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (cg || !c_req) begin
        c_req = ($urandom % 4) != 0;
        c_we = 1'($urandom % 2);
        c_addr = 8'($urandom_range(0, 15));
        c_wdata = $urandom;
      end
      if (lg || !l_req) begin
        l_req = ($urandom % 4) != 0;
        l_we = 1'($urandom % 2);
        l_addr = 8'($urandom_range(0, 15));
        l_wdata = $urandom;
      end
      if ($urandom % 8 == 0) l_lock = !l_lock;
      // reference: shared / locked / forced-core-slot behaviour
      ec = 0; el = 0;
      if (mode == 0) begin
        if (c_req && l_req) begin
          el = RR && fav_l;
          ec = !el;
          if (RR) fav_l = !fav_l;
        end else begin
          ec = c_req; el = l_req;
        end
        if (el && l_lock) begin mode = 1; run = 0; end
      end else if (mode == 1) begin
        el = l_req;
        if (c_req && l_req) run++;
        if (!l_lock) mode = 0;
        else if (c_req && run >= ML) mode = 2;
      end else begin
        ec = c_req;
        run = 0;
        mode = l_lock ? 1 : 0;
      end
      #1;
      nvec++;
      if (c_gnt !== ec || l_gnt !== el || c_stall !== (c_req && !ec) ||
          m_en !== (ec || el)) begin
        nerr++;
        $display("FAIL rnd_gnt n%0d got c%b l%b s%b en%b want c%b l%b",
                 n, c_gnt, l_gnt, c_stall, m_en, ec, el);
      end
      if (ec || el) begin
        nvec++;
        if (m_we !== (el ? l_we : c_we) ||
            m_addr !== (el ? l_addr : c_addr) ||
            ((el ? l_we : c_we) && m_wdata !== (el ? l_wdata : c_wdata))) begin
          nerr++;
          $display("FAIL rnd_cmd n%0d got we%b a%0d d%h", n, m_we,
                   m_addr, m_wdata);
        end
      end
      exp_rd = sh[el ? l_addr : c_addr];
      if (ec && c_we) sh[c_addr] = c_wdata;
      if (el && l_we) sh[l_addr] = l_wdata;
      ecr = ec && !c_we;
      elr = el && !l_we;
      cg = ec; lg = el;
      @(posedge clk); #1;
      nvec++;
      if (c_rvalid !== ecr || l_rvalid !== elr) begin
        nerr++;
        $display("FAIL rnd_rv n%0d got c%b l%b want c%b l%b",
                 n, c_rvalid, l_rvalid, ecr, elr);
      end
      if (ecr || elr) begin
        nvec++;
        if ((ecr ? c_rdata : l_rdata) !== exp_rd) begin
          nerr++;
          $display("FAIL rnd_data n%0d got %h want %h", n,
                   ecr ? c_rdata : l_rdata, exp_rd);
        end
      end
    end
    @(negedge clk);
    idle_in();
  endtask

  initial begin
    test_reset();
    preload();
    test_core_read();
    test_contention();
    test_reset_mid_read();
    test_write_then_read();
    test_lock_break();
    test_random();
    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
